// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling FSM and a
// valid/ready holding register. Define UART_RX_PARITY_EN to add an even-parity bit.
module uart_rx #(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       RXD,
   output logic [7:0] DATA,
   output logic       VALID,
   input  logic       READY,
   output logic       BUSY,
   output logic       OVERRUN,
   output logic       FRAME_ERR,
   output logic       PARITY_ERR
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_STOP      = 3'd3;
   localparam logic [2:0] S_WAIT_HIGH = 3'd4;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PARITY    = 3'd5;
`endif

   logic             rx_meta;
   logic             rxs;
   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       rx_byte;
   logic             deliver_pend;
`ifdef UART_RX_PARITY_EN
   logic             parity_bad;
`endif

   // Both flops reset high so a released reset looks like an idle line.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= RXD;
         rxs     <= rx_meta;
      end
   end

   // Receive FSM; every state entry restarts the baud counter at zero.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state        <= S_IDLE;
         cnt          <= '0;
         bit_idx      <= '0;
         rx_byte      <= '0;
         deliver_pend <= 1'b0;
         FRAME_ERR    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_bad   <= 1'b0;
         PARITY_ERR   <= 1'b0;
`endif
      end else begin
         deliver_pend <= 1'b0;
         FRAME_ERR    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         PARITY_ERR   <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (!rxs) begin
                  state <= S_START;
                  cnt   <= '0;
               end
            end
            S_START: begin
               if (cnt == CNT_HALF) begin
                  cnt <= '0;
                  if (rxs) begin
                     state <= S_IDLE;
                  end else begin
                     state   <= S_DATA;
                     bit_idx <= '0;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt              <= '0;
                  rx_byte[bit_idx] <= rxs;
                  bit_idx          <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= S_PARITY;
`else
                     state <= S_STOP;
`endif
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (cnt == CNT_LAST) begin
                  cnt        <= '0;
                  parity_bad <= ^{rx_byte, rxs};
                  state      <= S_STOP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
`endif
            S_STOP: begin
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (rxs) begin
                     state <= S_IDLE;
`ifdef UART_RX_PARITY_EN
                     if (parity_bad) PARITY_ERR   <= 1'b1;
                     else            deliver_pend <= 1'b1;
`else
                     deliver_pend <= 1'b1;
`endif
                  end else begin
                     // A low stop bit wins over a parity mismatch.
                     FRAME_ERR <= 1'b1;
                     state     <= S_WAIT_HIGH;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_WAIT_HIGH: begin
               if (rxs) begin
                  state <= S_IDLE;
                  cnt   <= '0;
               end
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Holding register: a pending byte is accepted if the slot is free or drains this cycle.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         DATA    <= 8'h00;
         VALID   <= 1'b0;
         OVERRUN <= 1'b0;
      end else begin
         OVERRUN <= 1'b0;
         if (deliver_pend) begin
            if (!VALID || READY) begin
               DATA  <= rx_byte;
               VALID <= 1'b1;
            end else begin
               OVERRUN <= 1'b1;
            end
         end else if (VALID && READY) begin
            VALID <= 1'b0;
         end
      end
   end

   assign BUSY = (state != S_IDLE);

`ifndef UART_RX_PARITY_EN
   assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 8 clocks per bit; frames are driven on the
// falling clock edge and all outputs are sampled there.
module tb_uart_rx;

   localparam int BIT = 8;
`ifdef UART_RX_PARITY_EN
   localparam int LATENCY = 2 + BIT / 2 + 10 * BIT + 1;
`else
   localparam int LATENCY = 2 + BIT / 2 + 9 * BIT + 1;
`endif

   logic       CLK   = 1'b0;
   logic       RESET = 1'b0;
   logic       RXD   = 1'b1;
   logic       READY = 1'b1;
   logic [7:0] DATA;
   logic       VALID;
   logic       BUSY;
   logic       OVERRUN;
   logic       FRAME_ERR;
   logic       PARITY_ERR;

   int total = 0;
   int bad   = 0;

   int   cyc        = 0;
   int   start_edge = 0;
   int   rise_cnt   = 0;
   int   rise_cyc   = 0;
   int   high_cnt   = 0;
   int   ov_cnt     = 0;
   int   fe_cnt     = 0;
   int   pe_cnt     = 0;
   logic valid_q    = 1'b0;

   int r0, h0, o0, f0, p0;

`ifdef UART_RX_PARITY_EN
   logic flip_parity = 1'b0;
`endif

   uart_rx #(.CLKS_PER_BIT(BIT)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .RXD        (RXD),
      .DATA       (DATA),
      .VALID      (VALID),
      .READY      (READY),
      .BUSY       (BUSY),
      .OVERRUN    (OVERRUN),
      .FRAME_ERR  (FRAME_ERR),
      .PARITY_ERR (PARITY_ERR)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Pulse and VALID-edge bookkeeping, sampled mid-cycle.
   always @(negedge CLK) begin
      valid_q <= VALID;
      if (VALID && !valid_q) begin
         rise_cnt <= rise_cnt + 1;
         rise_cyc <= cyc;
      end
      if (VALID)      high_cnt <= high_cnt + 1;
      if (OVERRUN)    ov_cnt   <= ov_cnt + 1;
      if (FRAME_ERR)  fe_cnt   <= fe_cnt + 1;
      if (PARITY_ERR) pe_cnt   <= pe_cnt + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drives one frame starting at the current falling edge; leaves RXD at the stop level.
   task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
      RXD        = 1'b0;
      start_edge = cyc + 1;
      repeat (BIT) @(negedge CLK);
      for (int i = 0; i < 8; i++) begin
         RXD = b[i];
         repeat (BIT) @(negedge CLK);
      end
`ifdef UART_RX_PARITY_EN
      RXD = (^b) ^ flip_parity;
      repeat (BIT) @(negedge CLK);
`endif
      RXD = stop_bit;
      repeat (BIT) @(negedge CLK);
   endtask

   task automatic snapshot();
      r0 = rise_cnt;
      h0 = high_cnt;
      o0 = ov_cnt;
      f0 = fe_cnt;
      p0 = pe_cnt;
   endtask

   initial begin
      repeat (3) @(negedge CLK);
      checkOutput("rst_data",   32'(DATA),       32'h00);
      checkOutput("rst_valid",  32'(VALID),      32'h0);
      checkOutput("rst_busy",   32'(BUSY),       32'h0);
      checkOutput("rst_ovr",    32'(OVERRUN),    32'h0);
      checkOutput("rst_frame",  32'(FRAME_ERR),  32'h0);
      checkOutput("rst_parity", 32'(PARITY_ERR), 32'h0);
      RESET = 1'b1;
      repeat (4) @(negedge CLK);

      $display("[TB] single byte 0x55, READY high");
      snapshot();
      applyStimulus(8'h55, 1'b1);
      repeat (8) @(negedge CLK);
      checkOutput("t1_data",    32'(DATA),              32'h55);
      checkOutput("t1_vcycles", 32'(high_cnt - h0),     32'd1);
      checkOutput("t1_latency", 32'(rise_cyc - start_edge), 32'(LATENCY));
      checkOutput("t1_ovr",     32'(ov_cnt - o0),       32'd0);
      checkOutput("t1_frame",   32'(fe_cnt - f0),       32'd0);
      checkOutput("t1_parity",  32'(pe_cnt - p0),       32'd0);

      $display("[TB] back-to-back 0xA3, 0x3C with READY low");
      READY = 1'b0;
      snapshot();
      applyStimulus(8'hA3, 1'b1);
      applyStimulus(8'h3C, 1'b1);
      repeat (8) @(negedge CLK);
      checkOutput("t2_data",   32'(DATA),         32'hA3);
      checkOutput("t2_valid",  32'(VALID),        32'h1);
      checkOutput("t2_rises",  32'(rise_cnt - r0), 32'd1);
      checkOutput("t2_ovr",    32'(ov_cnt - o0),  32'd1);
      checkOutput("t2_frame",  32'(fe_cnt - f0),  32'd0);
      READY = 1'b1;
      @(negedge CLK);
      READY = 1'b0;
      repeat (2) @(negedge CLK);
      checkOutput("t2_consumed_valid", 32'(VALID), 32'h0);
      checkOutput("t2_consumed_data",  32'(DATA),  32'hA3);

      $display("[TB] 0xFF with low stop bit, line held low");
      READY = 1'b1;
      snapshot();
      applyStimulus(8'hFF, 1'b0);
      repeat (40) @(negedge CLK);
      checkOutput("t3_busy_low_line", 32'(BUSY),          32'h1);
      checkOutput("t3_frame",         32'(fe_cnt - f0),   32'd1);
      checkOutput("t3_rises",         32'(rise_cnt - r0), 32'd0);
      checkOutput("t3_ovr",           32'(ov_cnt - o0),   32'd0);
      RXD = 1'b1;
      repeat (4) @(negedge CLK);
      checkOutput("t3_busy_released", 32'(BUSY),          32'h0);
      checkOutput("t3_valid",         32'(VALID),         32'h0);
      checkOutput("t3_frame_after",   32'(fe_cnt - f0),   32'd1);

      $display("[TB] 3-cycle glitch on the line");
      snapshot();
      RXD = 1'b0;
      repeat (3) @(negedge CLK);
      checkOutput("t4_busy_start", 32'(BUSY), 32'h1);
      RXD = 1'b1;
      repeat (BIT / 2 + 2) @(negedge CLK);
      checkOutput("t4_busy_end", 32'(BUSY),          32'h0);
      checkOutput("t4_rises",    32'(rise_cnt - r0), 32'd0);
      checkOutput("t4_frame",    32'(fe_cnt - f0),   32'd0);
      checkOutput("t4_parity",   32'(pe_cnt - p0),   32'd0);

      $display("[TB] reset during data bit 4");
      READY = 1'b0;
      applyStimulus(8'h5A, 1'b1);
      repeat (4) @(negedge CLK);
      checkOutput("t5_pre_valid", 32'(VALID), 32'h1);
      checkOutput("t5_pre_data",  32'(DATA),  32'h5A);
      snapshot();
      fork
         applyStimulus(8'hF0, 1'b1);
         begin
            repeat (5 * BIT + BIT / 2) @(negedge CLK);
            RESET = 1'b0;
            @(negedge CLK);
            checkOutput("t5_rst_data",  32'(DATA),      32'h00);
            checkOutput("t5_rst_valid", 32'(VALID),     32'h0);
            checkOutput("t5_rst_busy",  32'(BUSY),      32'h0);
            checkOutput("t5_rst_ovr",   32'(OVERRUN),   32'h0);
            checkOutput("t5_rst_frame", 32'(FRAME_ERR), 32'h0);
            RESET = 1'b1;
         end
      join
      repeat (4) @(negedge CLK);
      checkOutput("t5_abort_rises", 32'(rise_cnt - r0), 32'd0);
      checkOutput("t5_abort_frame", 32'(fe_cnt - f0),   32'd0);
      checkOutput("t5_abort_ovr",   32'(ov_cnt - o0),   32'd0);
      applyStimulus(8'h81, 1'b1);
      repeat (4) @(negedge CLK);
      checkOutput("t5_data",  32'(DATA),         32'h81);
      checkOutput("t5_valid", 32'(VALID),        32'h1);
      checkOutput("t5_ovr",   32'(ov_cnt - o0),  32'd0);

`ifdef UART_RX_PARITY_EN
      $display("[TB] even parity on 0x07");
      READY = 1'b1;
      repeat (2) @(negedge CLK);
      snapshot();
      flip_parity = 1'b0;
      applyStimulus(8'h07, 1'b1);
      repeat (4) @(negedge CLK);
      checkOutput("t6_good_data",   32'(DATA),          32'h07);
      checkOutput("t6_good_rises",  32'(rise_cnt - r0), 32'd1);
      checkOutput("t6_good_parity", 32'(pe_cnt - p0),   32'd0);
      snapshot();
      flip_parity = 1'b1;
      applyStimulus(8'h07, 1'b1);
      repeat (4) @(negedge CLK);
      flip_parity = 1'b0;
      checkOutput("t6_bad_parity", 32'(pe_cnt - p0),   32'd1);
      checkOutput("t6_bad_rises",  32'(rise_cnt - r0), 32'd0);
      checkOutput("t6_bad_valid",  32'(VALID),         32'h0);
      checkOutput("t6_bad_frame",  32'(fe_cnt - f0),   32'd0);
      checkOutput("t6_bad_ovr",    32'(ov_cnt - o0),   32'd0);
`else
      checkOutput("parity_never", 32'(pe_cnt), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver for the SOC serial input RXD; the receive-direction counterpart of the SOC's existing TXD transmitter.
- Sits between the RXD pad and the memory-mapped I/O block.
- Synchronises the asynchronous line, samples at mid-bit and delivers each byte through a valid/ready holding register.
- Flags overrun and framing errors as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 104, CLK cycles per bit (12 MHz / 115200); legal range >= 4.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RESET  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- RXD  input  1  serial line, idle high, asynchronous to CLK.
- DATA  output  8  last received byte, LSB is the first data bit on the line.
- VALID  output  1  DATA holds an unconsumed byte.
- READY  input  1  consumer accepts DATA on a CLK edge where VALID=1 and READY=1.
- BUSY  output  1  high whenever FSM is not IDLE.
- OVERRUN  output  1  one-cycle pulse when a complete byte is dropped.
- FRAME_ERR  output  1  one-cycle pulse when the stop bit samples 0.
- PARITY_ERR  output  1  one-cycle pulse on parity mismatch; see Optional Feature.

Behaviour:
- Reset values:
  - DATA=8'h00, VALID=0, BUSY=0, OVERRUN=0, FRAME_ERR=0, PARITY_ERR=0.
  - Both synchroniser flops=1, FSM=IDLE, all counters=0.
  - Reset mid-frame aborts the frame; no byte or error is reported for it.
- Input sync:
  - RXD passes through 2 flops (rxs); all FSM decisions use rxs.
  - Line-to-FSM latency is 2 cycles.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps.
  - Restarted at every state entry.
  - Width is $clog2(CLKS_PER_BIT).
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
  - IDLE: rxs==0 -> START, counter=0.
  - START: at count CLKS_PER_BIT/2-1, sample rxs.
    - rxs=1 -> IDLE (glitch; no error reported).
    - rxs=0 -> DATA, bit index=0, counter=0.
  - DATA: at each count CLKS_PER_BIT-1, shift rxs into bit[index], index++. After index 7 -> STOP (or PARITY).
  - STOP: at count CLKS_PER_BIT-1, sample rxs.
    - rxs=1 -> deliver, then IDLE.
    - rxs=0 -> FRAME_ERR pulse, byte discarded, -> WAIT_HIGH.
  - WAIT_HIGH: stay until rxs==1, then -> IDLE (prevents a break condition from re-triggering START).
- Deliver (registered, effective the cycle after the stop sample):
  - If VALID==0, or VALID&READY in that same cycle: DATA<=byte, VALID<=1.
  - Else: OVERRUN pulse; old DATA and VALID kept; new byte lost.
- Consume:
  - VALID&READY with no simultaneous deliver -> VALID<=0 next edge; DATA holds its value.
  - Simultaneous consume and deliver -> VALID stays 1, DATA takes the new byte.
- READY while VALID==0 is ignored.
- Errors:
  - Error pulses are exactly 1 cycle.
  - Errors never modify DATA or VALID.
  - FRAME_ERR and OVERRUN are mutually exclusive.
- End-to-end latency: VALID rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the RXD falling edge (for 8N1; add CLKS_PER_BIT with parity).

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state sits between DATA and STOP and samples 1 bit at count CLKS_PER_BIT-1.
  - Parity is even: XOR of 8 data bits and the parity bit must be 0.
  - On mismatch: PARITY_ERR pulses at the stop sample, the byte is discarded (no deliver, no OVERRUN), and the FSM proceeds to STOP for stop-bit checking.
  - If both parity and stop bit fail, only FRAME_ERR pulses.
- Undefined: no PARITY state; the port remains but PARITY_ERR is tied 0.

Test Plan:
- CLKS_PER_BIT=8, READY=1, send 0x55 8N1 -> VALID high exactly 1 cycle, DATA=0x55, latency 2+4+72+1=79 cycles from the start edge, no error pulses.
- READY=0, send 0xA3 then 0x3C back to back -> DATA=0xA3, VALID stays 1, OVERRUN pulses once at the second frame. Then READY=1 for 1 cycle -> VALID=0, DATA=0xA3.
- Send 0xFF with stop bit 0, then hold RXD low 40 cycles -> FRAME_ERR one pulse, VALID=0, BUSY stays 1 until RXD returns high, then BUSY=0.
- RXD low for 3 cycles, then high -> no VALID, no errors, BUSY returns 0 within CLKS_PER_BIT/2+2 cycles.
- Drive RESET=0 mid-way through data bit 4 of a frame, release, then send 0x81 -> all outputs 0 during reset, no report for the aborted frame, then DATA=0x81 with VALID.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 1 -> DATA=0x07 accepted. Send 0x07 with parity bit 0 -> PARITY_ERR pulse, VALID stays 0.
